hamming_codec_scheduler: RTL and testbench

- Shares one combinational 2D interleaved Hamming codec instance (44-bit data, 105-bit codeword) between an encode requester and a decode requester.
- Arbitrates the two requesters round-robin and registers the selected operand onto the codec inputs.
- Waits a programmable settle time, captures the codec outputs, and returns one result at a time over a valid/ready result port.
- Sits between the link framing logic and the codec; optionally keeps an uncorrectable-error statistic.

---
 rtl/hamming_codec_pkg.sv | 19 +
 rtl/hamming_codec_scheduler_rr_arb2.sv | 26 ++
 rtl/hamming_codec_scheduler.sv | 123 ++++++++++++
 tb/tb_hamming_codec_scheduler.sv | 422 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hamming_codec_pkg.sv
// Shared widths and encodings for the Hamming codec scheduler and its helpers.
package hamming_codec_pkg;

  localparam int unsigned DATA_W = 44;
  localparam int unsigned CODE_W = 105;
  localparam int unsigned PAD_W  = 61;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } sched_state_t;

  typedef enum logic {
    OP_ENC = 1'b0,
    OP_DEC = 1'b1
  } op_t;

endpackage

// File: rtl/hamming_codec_scheduler_rr_arb2.sv
// Two-requester round-robin arbiter; requester A wins the first tie after reset.
module rr_arb2 (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic req_a,
  input  logic req_b,
  output logic gnt_a,
  output logic gnt_b
);

  // Set when B held the most recent grant, so A gets priority on the next tie.
  logic last_b_q;

  assign gnt_a = en & req_a & (~req_b | last_b_q);
  assign gnt_b = en & req_b & (~req_a | ~last_b_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_b_q <= 1'b1;
    end else if (gnt_a | gnt_b) begin
      last_b_q <= gnt_b;
    end
  end

endmodule

// File: rtl/hamming_codec_scheduler.sv
// Time-shares one combinational Hamming codec between encode and decode requesters.
// Define HAMMING_ERR_STATS_EN to build the uncorrectable-decode counter.
module hamming_codec_scheduler
  import hamming_codec_pkg::*;
#(
  parameter int unsigned SETTLE_CYC = 1,
  parameter int unsigned CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enc_valid,
  output logic              enc_ready,
  input  logic [DATA_W-1:0] enc_data,
  input  logic              dec_valid,
  output logic              dec_ready,
  input  logic [CODE_W-1:0] dec_data,
  output logic [DATA_W-1:0] codec_data_in,
  output logic [CODE_W-1:0] codec_received_in,
  input  logic [CODE_W-1:0] codec_encoded_out,
  input  logic [DATA_W-1:0] codec_corrected_out,
  input  logic              codec_error_flag,
  output logic              res_valid,
  input  logic              res_ready,
  output logic              res_is_dec,
  output logic [CODE_W-1:0] res_data,
  output logic              res_error,
  output logic [CNT_W-1:0]  err_count,
  input  logic              err_count_clr
);

  localparam logic [3:0] SettleLoad = 4'(SETTLE_CYC - 1);

  sched_state_t state_q, state_d;
  op_t          op_q;
  logic [3:0]   settle_q;
  logic         enc_gnt, dec_gnt;
  logic         accept, capture;

  rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (state_q == IDLE),
    .req_a (enc_valid),
    .req_b (dec_valid),
    .gnt_a (enc_gnt),
    .gnt_b (dec_gnt)
  );

  assign enc_ready = enc_gnt;
  assign dec_ready = dec_gnt;
  assign accept    = enc_gnt | dec_gnt;
  assign capture   = (state_q == EXEC) && (settle_q == 4'd0);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = EXEC;
      EXEC:    if (settle_q == 4'd0) state_d = RESP;
      RESP:    if (res_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operand registers are left alone outside accepts so the codec inputs stay quiet.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q           <= IDLE;
      op_q              <= OP_ENC;
      settle_q          <= 4'd0;
      codec_data_in     <= '0;
      codec_received_in <= '0;
      res_valid         <= 1'b0;
      res_is_dec        <= 1'b0;
      res_data          <= '0;
      res_error         <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        if (enc_gnt) begin
          codec_data_in <= enc_data;
          op_q          <= OP_ENC;
        end else begin
          codec_received_in <= dec_data;
          op_q              <= OP_DEC;
        end
        settle_q <= SettleLoad;
      end else if (state_q == EXEC && settle_q != 4'd0) begin
        settle_q <= settle_q - 4'd1;
      end
      if (capture) begin
        res_valid  <= 1'b1;
        res_is_dec <= (op_q == OP_DEC);
        res_data   <= (op_q == OP_DEC) ? {{PAD_W{1'b0}}, codec_corrected_out}
                                       : codec_encoded_out;
        res_error  <= (op_q == OP_DEC) & codec_error_flag;
      end else if (res_valid && res_ready) begin
        res_valid <= 1'b0;
      end
    end
  end

`ifdef HAMMING_ERR_STATS_EN
  logic [CNT_W-1:0] err_cnt_q;

  // Clear wins over a coincident increment; the count sticks at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_q <= '0;
    end else if (err_count_clr) begin
      err_cnt_q <= '0;
    end else if (capture && op_q == OP_DEC && codec_error_flag && err_cnt_q != '1) begin
      err_cnt_q <= err_cnt_q + 1'b1;
    end
  end

  assign err_count = err_cnt_q;
`else
  logic unused_err_count_clr;
  assign unused_err_count_clr = err_count_clr;
  assign err_count            = '0;
`endif

endmodule

// File: tb/tb_hamming_codec_scheduler.sv
// Bench for hamming_codec_scheduler: vector table, corner sequences and a randomized model check.
module tb_hamming_codec_scheduler;

  localparam int unsigned CntW = 16;
`ifdef HAMMING_ERR_STATS_EN
  localparam bit StatsEn = 1'b1;
`else
  localparam bit StatsEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Stand-in codec: Hamming(50,44) in codeword bits [49:0], upper bits ignored.
  function automatic logic [104:0] ham_enc(input logic [43:0] d);
    logic [104:0] c;
    int k;
    logic x;
    c = '0;
    k = 0;
    for (int p = 1; p <= 50; p++) begin
      if ((p & (p - 1)) != 0) begin
        c[p-1] = d[k];
        k++;
      end
    end
    for (int b = 0; b < 6; b++) begin
      x = 1'b0;
      for (int p = 1; p <= 50; p++) if (((p >> b) & 1) == 1) x ^= c[p-1];
      c[(1<<b)-1] = x;
    end
    return c;
  endfunction

  function automatic logic [43:0] ham_dec(input logic [104:0] r);
    logic [104:0] c;
    logic [43:0] d;
    int syn;
    int k;
    c = r;
    syn = 0;
    for (int p = 1; p <= 50; p++) if (c[p-1]) syn ^= p;
    if (syn >= 1 && syn <= 50) c[syn-1] = ~c[syn-1];
    k = 0;
    d = '0;
    for (int p = 1; p <= 50; p++) begin
      if ((p & (p - 1)) != 0) begin
        d[k] = c[p-1];
        k++;
      end
    end
    return d;
  endfunction

  // DUT with SETTLE_CYC = 1
  logic          enc_valid, enc_ready, dec_valid, dec_ready;
  logic [43:0]   enc_data, codec_data_in, codec_corrected_out;
  logic [104:0]  dec_data, codec_received_in, codec_encoded_out, res_data;
  logic          res_valid, res_ready, res_is_dec, res_error, err_count_clr, force_err;
  logic [CntW-1:0] err_count;

  assign codec_encoded_out   = ham_enc(codec_data_in);
  assign codec_corrected_out = ham_dec(codec_received_in);

  hamming_codec_scheduler #(.SETTLE_CYC(1), .CNT_W(CntW)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .enc_valid           (enc_valid),
    .enc_ready           (enc_ready),
    .enc_data            (enc_data),
    .dec_valid           (dec_valid),
    .dec_ready           (dec_ready),
    .dec_data            (dec_data),
    .codec_data_in       (codec_data_in),
    .codec_received_in   (codec_received_in),
    .codec_encoded_out   (codec_encoded_out),
    .codec_corrected_out (codec_corrected_out),
    .codec_error_flag    (force_err),
    .res_valid           (res_valid),
    .res_ready           (res_ready),
    .res_is_dec          (res_is_dec),
    .res_data            (res_data),
    .res_error           (res_error),
    .err_count           (err_count),
    .err_count_clr       (err_count_clr)
  );

  // DUT with SETTLE_CYC = 3
  logic          b_enc_valid, b_enc_ready, b_dec_valid, b_dec_ready;
  logic [43:0]   b_enc_data, b_cdi, b_cco;
  logic [104:0]  b_dec_data, b_cri, b_ceo, b_res_data;
  logic          b_res_valid, b_res_ready, b_res_is_dec, b_res_error, b_err_clr;
  logic [CntW-1:0] b_err_count;

  assign b_ceo = ham_enc(b_cdi);
  assign b_cco = ham_dec(b_cri);

  hamming_codec_scheduler #(.SETTLE_CYC(3), .CNT_W(CntW)) dut_s3 (
    .clk                 (clk),
    .rst_n               (rst_n),
    .enc_valid           (b_enc_valid),
    .enc_ready           (b_enc_ready),
    .enc_data            (b_enc_data),
    .dec_valid           (b_dec_valid),
    .dec_ready           (b_dec_ready),
    .dec_data            (b_dec_data),
    .codec_data_in       (b_cdi),
    .codec_received_in   (b_cri),
    .codec_encoded_out   (b_ceo),
    .codec_corrected_out (b_cco),
    .codec_error_flag    (1'b0),
    .res_valid           (b_res_valid),
    .res_ready           (b_res_ready),
    .res_is_dec          (b_res_is_dec),
    .res_data            (b_res_data),
    .res_error           (b_res_error),
    .err_count           (b_err_count),
    .err_count_clr       (b_err_clr)
  );

  task automatic check(input string name, input logic [104:0] act, input logic [104:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    enc_valid = 0; dec_valid = 0; enc_data = '0; dec_data = '0;
    res_ready = 1; err_count_clr = 0; force_err = 0;
    b_enc_valid = 0; b_dec_valid = 0; b_enc_data = '0; b_dec_data = '0;
    b_res_ready = 1; b_err_clr = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // One request on the SETTLE_CYC=1 DUT; clr pulses err_count_clr on the capture edge.
  task automatic transact(input bit is_dec, input logic [104:0] payload, input bit ferr,
                          input bit clr, output logic [104:0] rdata, output logic rerr,
                          output logic risdec, output int lat);
    int n;
    res_ready = 1'b1;
    enc_valid = !is_dec;
    dec_valid = is_dec;
    enc_data  = payload[43:0];
    dec_data  = payload;
    force_err = ferr;
    #1;
    n = 0;
    while (!(is_dec ? dec_ready : enc_ready) && n < 20) begin
      tick();
      #1;
      n++;
    end
    check("accept_seen", n < 20, 1);
    tick();
    enc_valid = 1'b0;
    dec_valid = 1'b0;
    err_count_clr = clr;
    lat = 0;
    do begin
      tick();
      lat++;
      err_count_clr = 1'b0;
    end while (!res_valid && lat < 40);
    rdata  = res_data;
    rerr   = res_error;
    risdec = res_is_dec;
    tick();
    check("res_valid_drop", res_valid, 0);
  endtask

  typedef struct {
    bit           is_dec;
    logic [104:0] payload;
    bit           ferr;
    logic [104:0] exp_data;
    bit           exp_err;
  } vec_t;

  localparam logic [43:0] KData = 44'h0_1234_5678_9;
  localparam logic [43:0] KAlt  = 44'hA_5A5A_C3C3_1;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs [7];
    logic [104:0] rd, rd2, snap, flip;
    logic rerr, risdec;
    int lat, exp_cnt, n, delivered;
    int g[$];
    int gc[$];
    bit both;
    logic [43:0] rnd44;
    // model state for the randomized run
    bit m_busy, m_have, m_last_dec, m_isdec, m_err, m_ferr, m_eg, m_dg, cap;
    int m_wait, m_cnt;
    logic [104:0] m_data;

    vecs[0] = '{0, {61'b0, KData}, 0, ham_enc(KData), 0};
    vecs[1] = '{1, ham_enc(KData), 0, {61'b0, KData}, 0};
    vecs[2] = '{1, ham_enc(KData) ^ (105'b1 << 7), 0, {61'b0, KData}, 0};
    vecs[3] = '{1, ham_enc(KAlt) ^ (105'b1 << 30), 1, {61'b0, KAlt}, 1};
    vecs[4] = '{1, ham_enc(KData), 1, {61'b0, KData}, 1};
    vecs[5] = '{0, {61'b0, 44'hFFF_FFFF_FFFF}, 1, ham_enc(44'hFFF_FFFF_FFFF), 0};
    vecs[6] = '{0, 105'b0, 0, 105'b0, 0};

    // Reset values
    do_reset();
    #1;
    check("rst_res_valid", res_valid, 0);
    check("rst_res_is_dec", res_is_dec, 0);
    check("rst_res_data", res_data, 0);
    check("rst_res_error", res_error, 0);
    check("rst_err_count", err_count, 0);
    check("rst_codec_data_in", codec_data_in, 0);
    check("rst_codec_received_in", codec_received_in, 0);
    check("rst_ready", {enc_ready, dec_ready}, 0);
    check("rst_b_res_valid", b_res_valid, 0);

    // Table-driven vectors
    exp_cnt = 0;
    for (int i = 0; i < 7; i++) begin
      transact(vecs[i].is_dec, vecs[i].payload, vecs[i].ferr, 0, rd, rerr, risdec, lat);
      if (StatsEn && vecs[i].is_dec && vecs[i].ferr) exp_cnt++;
      check($sformatf("vec%0d_data", i), rd, vecs[i].exp_data);
      check($sformatf("vec%0d_error", i), rerr, vecs[i].exp_err);
      check($sformatf("vec%0d_is_dec", i), risdec, vecs[i].is_dec);
      check($sformatf("vec%0d_latency", i), lat, 1);
      check($sformatf("vec%0d_err_count", i), err_count, exp_cnt);
    end

    // Encode/decode round trip through the DUT's own codeword
    transact(0, {61'b0, KData}, 0, 0, rd, rerr, risdec, lat);
    transact(1, rd, 0, 0, rd2, rerr, risdec, lat);
    check("rt_low", rd2[43:0], 44'h0_1234_5678_9);
    check("rt_pad", rd2[104:44], 0);
    check("rt_error", rerr, 0);
    check("rt_latency", lat, 1);

    // Clear coincides with a third failing capture
    check("cnt_before_clr", err_count, StatsEn ? 2 : 0);
    transact(1, ham_enc(KAlt), 1, 1, rd, rerr, risdec, lat);
    check("clr_res_error", rerr, 1);
    check("clr_err_count", err_count, 0);

    // Fairness with both requesters always valid
    do_reset();
    enc_valid = 1; dec_valid = 1;
    enc_data = KData; dec_data = ham_enc(KAlt);
    both = 0;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (enc_ready && dec_ready) both = 1;
      if (enc_ready) begin
        g.push_back(0);
        gc.push_back(c);
      end else if (dec_ready) begin
        g.push_back(1);
        gc.push_back(c);
      end
      tick();
    end
    enc_valid = 0; dec_valid = 0;
    check("fair_never_both", both, 0);
    check("fair_grant_count", g.size() >= 4, 1);
    for (int i = 0; i < 4; i++) begin
      if (i < g.size()) check($sformatf("fair_grant%0d", i), g[i], i % 2);
      if (i > 0 && i < gc.size()) check($sformatf("fair_ii%0d", i), gc[i] - gc[i-1], 3);
    end

    // Randomized run against the behavioural model
    do_reset();
    m_busy = 0; m_have = 0; m_last_dec = 1; m_wait = 0; m_cnt = 0;
    m_isdec = 0; m_err = 0; m_ferr = 0; m_data = '0;
    for (int c = 0; c < 400; c++) begin
      enc_valid = ($urandom_range(0, 2) != 0);
      dec_valid = ($urandom_range(0, 2) != 0);
      enc_data  = 44'({$urandom(), $urandom()});
      rnd44     = 44'({$urandom(), $urandom()});
      flip      = ($urandom_range(0, 1) == 1) ? (105'b1 << $urandom_range(0, 49)) : 105'b0;
      dec_data  = ($urandom_range(0, 4) == 0) ? 105'({$urandom(), $urandom(), $urandom(),
                                                       $urandom()})
                                              : (ham_enc(rnd44) ^ flip);
      if (!m_busy) force_err = ($urandom_range(0, 2) == 0);
      res_ready = ($urandom_range(0, 3) != 0);
      err_count_clr = ($urandom_range(0, 15) == 0);
      #1;
      m_eg = !m_busy && enc_valid && (!dec_valid || m_last_dec);
      m_dg = !m_busy && dec_valid && (!enc_valid || !m_last_dec);
      check("rnd_enc_ready", enc_ready, m_eg);
      check("rnd_dec_ready", dec_ready, m_dg);
      check("rnd_res_valid", res_valid, m_have);
      if (m_have) begin
        check("rnd_res_data", res_data, m_data);
        check("rnd_res_error", res_error, m_err);
        check("rnd_res_is_dec", res_is_dec, m_isdec);
      end
      check("rnd_err_count", err_count, StatsEn ? m_cnt : 0);
      cap = 0;
      if (m_have && res_ready) begin
        m_have = 0;
        m_busy = 0;
      end else if (m_busy && !m_have) begin
        m_wait--;
        if (m_wait == 0) begin
          m_have = 1;
          cap = 1;
        end
      end
      if (err_count_clr) m_cnt = 0;
      else if (cap && m_isdec && m_ferr && m_cnt != 65535) m_cnt++;
      if (m_eg || m_dg) begin
        m_busy = 1;
        m_wait = 1;
        m_last_dec = m_dg;
        m_isdec = m_dg;
        m_ferr = force_err;
        m_data = m_dg ? {61'b0, ham_dec(dec_data)} : ham_enc(enc_data);
        m_err = m_dg & force_err;
      end
      tick();
    end

    // Backpressure on the SETTLE_CYC=3 instance
    do_reset();
    b_res_ready = 0;
    b_enc_valid = 1;
    b_enc_data = KAlt;
    #1;
    check("bp_accept", b_enc_ready, 1);
    tick();
    b_dec_valid = 1;
    b_dec_data = ham_enc(KData);
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!b_res_valid && lat < 40);
    check("bp_latency", lat, 3);
    snap = b_res_data;
    check("bp_data", snap, ham_enc(KAlt));
    for (int c = 0; c < 5; c++) begin
      #1;
      check("bp_hold_valid", b_res_valid, 1);
      check("bp_hold_data", b_res_data, snap);
      check("bp_hold_ready", {b_enc_ready, b_dec_ready}, 0);
      tick();
    end
    b_res_ready = 1;
    b_enc_valid = 0;
    b_dec_valid = 0;
    delivered = 0;
    for (int c = 0; c < 6; c++) begin
      #1;
      if (b_res_valid && b_res_ready) delivered++;
      tick();
    end
    check("bp_delivered", delivered, 1);

    // Reset mid-operation: A waits in RESP, B sits in EXEC
    res_ready = 0;
    enc_valid = 1;
    enc_data = KData;
    b_dec_valid = 1;
    b_dec_data = ham_enc(KAlt);
    #1;
    check("mid_accept", {enc_ready, b_dec_ready}, 2'b11);
    tick();
    enc_valid = 0;
    b_dec_valid = 0;
    tick();
    check("mid_pending", res_valid, 1);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_async_drop", res_valid, 0);
    check("mid_b_valid", b_res_valid, 0);
    idle_inputs();
    tick();
    tick();
    rst_n = 1'b1;
    n = 0;
    for (int c = 0; c < 8; c++) begin
      #1;
      if (res_valid || b_res_valid) n++;
      tick();
    end
    check("mid_no_result", n, 0);
    enc_valid = 1; dec_valid = 1;
    b_enc_valid = 1; b_dec_valid = 1;
    #1;
    check("mid_first_grant", {enc_ready, dec_ready}, 2'b10);
    check("mid_b_first_grant", {b_enc_ready, b_dec_ready}, 2'b10);
    idle_inputs();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
